// File: rtl/mant_pkg.sv
// mant_pkg: shared types, segment constants and digit lookup for the maintenance display
package mant_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [7:0] ALARM_CODE = 8'hFF;
  function automatic logic [6:0] seg_of(input bcd_t d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-bit sequential double-dabble, one shift per clock, done pulses in COMMIT
module bin2bcd_seq import mant_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] val,
  output bcd_t       hun,
  output bcd_t       tens,
  output bcd_t       ones
);
  state_t state;
  logic [19:0] sr;
  logic [19:0] adj;
  logic [2:0] cnt;
  function automatic bcd_t dab(input bcd_t d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
  // nibble correction applied before every shift
  always_comb begin
    adj = {dab(sr[19:16]), dab(sr[15:12]), dab(sr[11:8]), sr[7:0]};
  end
  // capture on start, eight shift steps, then one commit cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      val <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sr <= {12'd0, din};
          val <= din;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          sr <= {adj[18:0], 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= COMMIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign done = state == COMMIT;
  assign {hun, tens, ones} = sr[19:8];
endmodule

// File: rtl/mant_display.sv
// mant_display: converts the maintenance msg to decimal and scans it onto a 3-digit display
module mant_display import mant_pkg::*; #(
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] msg,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       busy,
  output logic       alarm
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic done;
  logic [7:0] work_val, cur_val;
  bcd_t c_hun, c_tens, c_ones, hun, tens, ones, dig;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic [1:0] idx;
  logic phase, tick, blank;
  logic [6:0] seg_d;
  bin2bcd_seq u_conv (
    .clk(clk),
    .rst(rst),
    .start(msg != cur_val),
    .din(msg),
    .busy(busy),
    .done(done),
    .val(work_val),
    .hun(c_hun),
    .tens(c_tens),
    .ones(c_ones)
  );
  // latch the finished conversion as the committed value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_val <= '0;
      {hun, tens, ones} <= '0;
      alarm <= 1'b0;
    end else if (done) begin
      cur_val <= work_val;
      {hun, tens, ones} <= {c_hun, c_tens, c_ones};
      alarm <= work_val == ALARM_CODE;
    end
  end
  // blink phase restarts ON when the alarm is newly committed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= '0;
      phase <= 1'b0;
    end else if (done && work_val == ALARM_CODE && !alarm) begin
      bcnt <= '0;
      phase <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
  assign tick = scnt == SW'(SCAN_DIV - 1);
  // pick the digit for the current slot with leading-zero blanking
  always_comb begin
    dig = idx == 2'd2 ? hun : idx == 2'd1 ? tens : ones;
    blank = (idx == 2'd2 && hun == '0) || (idx == 2'd1 && hun == '0 && tens == '0);
    seg_d = alarm ? (phase ? SEG_DASH : SEG_BLANK) : blank ? SEG_BLANK : seg_of(dig);
  end
  // digit dwell counter; outputs load the current slot then the index advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt <= '0;
      idx <= '0;
      seg_n <= SEG_BLANK;
      an_n <= 3'b111;
    end else if (tick) begin
      scnt <= '0;
      idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
      seg_n <= seg_d;
      an_n <= ~(3'b001 << idx);
    end else begin
      scnt <= scnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mant_display.sv
// tb_mant_display: scenario tasks plus a cycle-accurate arithmetic reference model
module tb_mant_display;
  localparam int S = 4;
  localparam int B = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] msg = 8'd0;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  logic busy, alarm;
  int total = 0;
  int bad = 0;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int n = 0;
  int m_done_at = 0;
  int m_rise = 0;
  logic [7:0] m_cur = 8'd0;
  logic [7:0] m_work = 8'd0;
  bit m_busy = 1'b0;
  bit m_alarm = 1'b0;
  logic [6:0] m_seg = 7'b1111111;
  logic [2:0] m_an = 3'b111;

  mant_display #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .msg(msg), .seg_n(seg_n), .an_n(an_n), .busy(busy), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int slot, input int v, input bit al, input bit on);
    if (al) return on ? 7'b0111111 : 7'b1111111;
    if (slot == 0) return seg_tab[v % 10];
    if (slot == 1) return v < 10 ? 7'b1111111 : seg_tab[(v / 10) % 10];
    return v < 100 ? 7'b1111111 : seg_tab[v / 100];
  endfunction

  // reference: n counts edges since reset release; conversions commit 9 edges after start
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n <= 0;
      m_cur <= 8'd0;
      m_work <= 8'd0;
      m_busy <= 1'b0;
      m_alarm <= 1'b0;
      m_done_at <= 0;
      m_rise <= 0;
      m_seg <= 7'b1111111;
      m_an <= 3'b111;
    end else begin
      automatic int e = n + 1;
      n <= e;
      if (e % S == 0) begin
        m_an <= ~(3'b001 << ((e / S - 1) % 3));
        m_seg <= exp_seg((e / S - 1) % 3, int'(m_cur), m_alarm, ((e - 1 - m_rise) / B) % 2 == 0);
      end
      if (m_busy) begin
        if (e == m_done_at) begin
          m_busy <= 1'b0;
          m_cur <= m_work;
          m_alarm <= m_work == 8'hFF;
          if (m_work == 8'hFF && !m_alarm) m_rise <= e;
        end
      end else if (msg != m_cur) begin
        m_busy <= 1'b1;
        m_work <= msg;
        m_done_at <= e + 9;
      end
    end
  end

  task automatic test_reset;
    msg = 8'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({an_n, seg_n, busy, alarm} !== {3'b111, 7'b1111111, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: an_n=%b seg_n=%b busy=%b alarm=%b want 111 1111111 0 0", an_n, seg_n, busy, alarm);
    end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (an_n !== 3'b110 || seg_n !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ones: an_n=%b seg_n=%b want 110 1000000", an_n, seg_n);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (an_n !== 3'b101 || seg_n !== 7'b1111111) begin
      bad++;
      $display("FAIL reset_tens: an_n=%b seg_n=%b want 101 1111111", an_n, seg_n);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (an_n !== 3'b011 || seg_n !== 7'b1111111) begin
      bad++;
      $display("FAIL reset_hund: an_n=%b seg_n=%b want 011 1111111", an_n, seg_n);
    end
  endtask

  task automatic test_convert;
    logic [6:0] got [3] = '{default: 7'h00};
    @(negedge clk);
    msg = 8'd125;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (busy !== (i < 9)) begin
        bad++;
        $display("FAIL convert_busy step %0d: busy=%b want %b", i, busy, i < 9);
      end
    end
    repeat (3 * S + 1) begin
      @(negedge clk);
      if (an_n == 3'b110) got[0] = seg_n;
      if (an_n == 3'b101) got[1] = seg_n;
      if (an_n == 3'b011) got[2] = seg_n;
    end
    total++;
    if (got[2] !== 7'b1111001) begin bad++; $display("FAIL convert_hund: seg=%b want 1111001", got[2]); end
    total++;
    if (got[1] !== 7'b0100100) begin bad++; $display("FAIL convert_tens: seg=%b want 0100100", got[1]); end
    total++;
    if (got[0] !== 7'b0010010) begin bad++; $display("FAIL convert_ones: seg=%b want 0010010", got[0]); end
  endtask

  task automatic test_alarm;
    int dash = 0;
    logic [6:0] got [3] = '{default: 7'h00};
    @(negedge clk);
    msg = 8'hFF;
    repeat (10) @(negedge clk);
    total++;
    if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_set: alarm=%b want 1", alarm); end
    repeat (S) @(negedge clk);
    total++;
    if (seg_n !== 7'b0111111) begin bad++; $display("FAIL alarm_first_on: seg_n=%b want 0111111", seg_n); end
    repeat (4 * B) begin
      @(negedge clk);
      if (seg_n == 7'b0111111) dash++;
      total++;
      if (seg_n !== m_seg || an_n !== m_an) begin
        bad++;
        $display("FAIL alarm_blink: seg_n=%b an_n=%b want %b %b", seg_n, an_n, m_seg, m_an);
      end
    end
    total++;
    if (dash != 2 * B) begin bad++; $display("FAIL alarm_duty: dash cycles=%0d want %0d", dash, 2 * B); end
    msg = 8'd3;
    repeat (10) @(negedge clk);
    total++;
    if (alarm !== 1'b0) begin bad++; $display("FAIL alarm_clear: alarm=%b want 0", alarm); end
    repeat (3 * S + 1) begin
      @(negedge clk);
      if (an_n == 3'b110) got[0] = seg_n;
      if (an_n == 3'b101) got[1] = seg_n;
      if (an_n == 3'b011) got[2] = seg_n;
    end
    total++;
    if (got[0] !== 7'b0110000 || got[1] !== 7'b1111111 || got[2] !== 7'b1111111) begin
      bad++;
      $display("FAIL alarm_to_3: ones=%b tens=%b hund=%b want 0110000 1111111 1111111", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_busy_change;
    logic [6:0] got [3] = '{default: 7'h00};
    @(negedge clk);
    msg = 8'd7;
    repeat (2) @(negedge clk);
    msg = 8'd200;
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL change_first_done: busy=%b want 0", busy); end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL change_reconvert: busy=%b want 1", busy); end
    repeat (9) begin
      @(negedge clk);
      total++;
      if (seg_n !== m_seg || an_n !== m_an || busy !== m_busy) begin
        bad++;
        $display("FAIL change_model: seg_n=%b an_n=%b busy=%b want %b %b %b", seg_n, an_n, busy, m_seg, m_an, m_busy);
      end
    end
    repeat (3 * S + 1) begin
      @(negedge clk);
      if (an_n == 3'b110) got[0] = seg_n;
      if (an_n == 3'b101) got[1] = seg_n;
      if (an_n == 3'b011) got[2] = seg_n;
    end
    total++;
    if (got[2] !== 7'b0100100 || got[1] !== 7'b1000000 || got[0] !== 7'b1000000) begin
      bad++;
      $display("FAIL change_200: hund=%b tens=%b ones=%b want 0100100 1000000 1000000", got[2], got[1], got[0]);
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] got [3] = '{default: 7'h00};
    @(negedge clk);
    msg = 8'd99;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({an_n, seg_n, busy, alarm} !== {3'b111, 7'b1111111, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_now: an_n=%b seg_n=%b busy=%b alarm=%b want 111 1111111 0 0", an_n, seg_n, busy, alarm);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midreset_restart: busy=%b want 1", busy); end
    repeat (3) @(negedge clk);
    total++;
    if (an_n !== 3'b110 || seg_n !== 7'b1000000) begin
      bad++;
      $display("FAIL midreset_nocommit: an_n=%b seg_n=%b want 110 1000000", an_n, seg_n);
    end
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_done: busy=%b want 0", busy); end
    repeat (3 * S + 1) begin
      @(negedge clk);
      if (an_n == 3'b110) got[0] = seg_n;
      if (an_n == 3'b101) got[1] = seg_n;
      if (an_n == 3'b011) got[2] = seg_n;
    end
    total++;
    if (got[2] !== 7'b1111111 || got[1] !== 7'b0010000 || got[0] !== 7'b0010000) begin
      bad++;
      $display("FAIL midreset_99: hund=%b tens=%b ones=%b want 1111111 0010000 0010000", got[2], got[1], got[0]);
    end
  endtask

  task automatic test_scan_wrap;
    logic [2:0] prev;
    int cnt = 0;
    prev = an_n;
    while (an_n == prev && cnt < 3 * S) begin @(negedge clk); cnt++; end
    for (int j = 0; j < 4; j++) begin
      prev = an_n;
      cnt = 0;
      while (an_n == prev && cnt < 3 * S) begin @(negedge clk); cnt++; end
      total++;
      if (cnt != S || an_n !== {prev[1:0], prev[2]}) begin
        bad++;
        $display("FAIL scan_wrap %0d: from %b held %0d then %b want held %0d then %b", j, prev, cnt, an_n, S, {prev[1:0], prev[2]});
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      msg = $urandom_range(0, 7) == 0 ? 8'hFF : 8'($urandom_range(0, 254));
      repeat ($urandom_range(1, 24)) begin
        @(negedge clk);
        total++;
        if ({seg_n, an_n, busy, alarm} !== {m_seg, m_an, m_busy, m_alarm}) begin
          bad++;
          $display("FAIL random %0d: seg_n=%b an_n=%b busy=%b alarm=%b want %b %b %b %b",
                   i, seg_n, an_n, busy, alarm, m_seg, m_an, m_busy, m_alarm);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_convert;
    test_alarm;
    test_busy_change;
    test_reset_mid;
    test_scan_wrap;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
